// File: rtl/de1_input_pkg.sv
// rtl/de1_input_pkg.sv - shared debounce state encoding and timing constants
package de1_input_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } key_state_t;

    // 20 ms of agreement at 50 MHz
    localparam int DEB_20MS_50MHZ = 1000000;

endpackage

// File: rtl/key_debounce_pulse_if.sv
// rtl/key_debounce_pulse_if.sv - raw key inputs and conditioned key outputs
interface key_debounce_pulse_if #(
    parameter int NUM_KEYS = 2
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;

    modport master (
        output key_n,
        input  key_level,
        input  key_press,
        input  key_release
    );

    modport slave (
        input  key_n,
        output key_level,
        output key_press,
        output key_release
    );
endinterface

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: two-FF sync, agreement counter, FSM, registered strobes
module key_debounce_ch
    import de1_input_pkg::*;
#(
    parameter int STABLE_CYCLES = DEB_20MS_50MHZ,
    parameter int CNT_W         = 20
) (
    input  logic clk,
    input  logic Reset,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic             p;
    key_state_t       state;
    key_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;

    assign p = ~sync2;

    always_ff @(posedge clk) begin
        if (!Reset) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            state       <= RELEASED;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync1       <= key_n;
            sync2       <= sync1;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_level   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
        end
    end

    // Strobes are decoded from the accepting transition, so each accepted edge yields one pulse
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        level_nxt   = key_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            RELEASED: begin
                if (p) begin
                    state_nxt = PRESS_CHK;
                    cnt_nxt   = '0;
                end
            end
            PRESS_CHK: begin
                if (!p) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!p) begin
                    state_nxt = RELEASE_CHK;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_CHK: begin
                if (p) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = RELEASED;
                    cnt_nxt     = '0;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_debounce_pulse.sv
// rtl/key_debounce_pulse.sv - debounced level plus press/release strobes for NUM_KEYS active-low keys
module key_debounce_pulse
    import de1_input_pkg::*;
#(
    parameter int NUM_KEYS      = 2,
    parameter int STABLE_CYCLES = DEB_20MS_50MHZ,
    parameter int CNT_W         = 20
) (
    input  logic                 clk,
    input  logic                 Reset,
    key_debounce_pulse_if.slave  keys
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk        (clk),
            .Reset      (Reset),
            .key_n      (keys.key_n[i]),
            .key_level  (keys.key_level[i]),
            .key_press  (keys.key_press[i]),
            .key_release(keys.key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb/tb_key_debounce_pulse.sv - directed and random checks against a run-length debounce model
module tb_key_debounce_pulse;

    localparam int NK = 2;
    localparam int SC = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    key_debounce_pulse_if #(.NUM_KEYS(NK)) bus ();

    key_debounce_pulse #(
        .NUM_KEYS     (NK),
        .STABLE_CYCLES(SC),
        .CNT_W        (CW)
    ) dut (
        .clk  (clk),
        .Reset(Reset),
        .keys (bus)
    );

    int total = 0;
    int bad   = 0;
    int press_events;

    // Model: a key's accepted level flips after SC consecutive synchronised samples disagree with it
    logic [NK-1:0] pend[$];
    logic [NK-1:0] m_level;
    logic [NK-1:0] m_press;
    logic [NK-1:0] m_rel;
    int            m_run[NK];

    task automatic check(string tag, logic [NK-1:0] obs, logic [NK-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(string tag, int obs, int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        pend.push_back('0);
        pend.push_back('0);
        m_level = '0;
        for (int k = 0; k < NK; k++) m_run[k] = 0;
    endtask

    task automatic tick();
        logic [NK-1:0] kn;
        logic          rs;
        logic [NK-1:0] p;
        kn = bus.key_n;
        rs = Reset;
        @(posedge clk);
        m_press = '0;
        m_rel   = '0;
        if (!rs) begin
            model_reset();
        end else begin
            p = pend.pop_front();
            pend.push_back(~kn);
            for (int k = 0; k < NK; k++) begin
                if (p[k] != m_level[k]) begin
                    m_run[k]++;
                    if (m_run[k] == SC) begin
                        m_level[k] = p[k];
                        m_run[k]   = 0;
                        if (p[k]) m_press[k] = 1'b1;
                        else      m_rel[k]   = 1'b1;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
        end
        #1;
        check("model_level", bus.key_level, m_level);
        check("model_press", bus.key_press, m_press);
        check("model_release", bus.key_release, m_rel);
        check("strobe_exclusive", bus.key_press & bus.key_release, '0);
        press_events += $countones(bus.key_press);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        Reset     = 1'b0;
        bus.key_n = 2'b00;
        press_events = 0;
        model_reset();

        // Keys held through reset come out as a fresh press
        run(3);
        check("s1_reset_level", bus.key_level, 2'b00);
        Reset = 1'b1;
        run(9);
        tick();
        check("s1_press", bus.key_press, 2'b11);
        tick();
        check("s1_level_held", bus.key_level, 2'b11);
        check("s1_single_pulse", bus.key_press, 2'b00);

        bus.key_n = 2'b11;
        run(20);
        bus.key_n = 2'b10;
        run(9);
        tick();
        check("s2_press", bus.key_press, 2'b01);
        run(10);
        bus.key_n = 2'b11;
        run(9);
        tick();
        check("s2_release", bus.key_release, 2'b01);
        check("s2_level", bus.key_level, 2'b00);

        run(5);
        press_events = 0;
        bus.key_n = 2'b10; run(3);
        bus.key_n = 2'b11; run(2);
        bus.key_n = 2'b10; run(7);
        bus.key_n = 2'b11; run(15);
        check_cnt("s3_glitch_no_strobe", press_events, 0);
        check("s3_level", bus.key_level, 2'b00);

        press_events = 0;
        for (int i = 0; i < 6; i++) begin
            bus.key_n[1] = (i % 2 == 1);
            run(2);
        end
        bus.key_n[1] = 1'b0;
        run(9);
        tick();
        check("s4_bounce_press", bus.key_press, 2'b10);
        run(5);
        check_cnt("s4_single_strobe", press_events, 1);
        bus.key_n = 2'b11;
        run(20);

        bus.key_n = 2'b10;
        run(7);
        Reset = 1'b0;
        tick();
        check("s5_reset_press", bus.key_press, 2'b00);
        check("s5_reset_level", bus.key_level, 2'b00);
        Reset = 1'b1;
        run(9);
        tick();
        check("s5_press_after_reset", bus.key_press, 2'b01);
        bus.key_n = 2'b11;
        run(20);

        bus.key_n = 2'b00;
        run(9);
        tick();
        check("s6_both_press", bus.key_press, 2'b11);
        run(5);
        bus.key_n = 2'b01;
        run(9);
        tick();
        check("s6_release0", bus.key_release, 2'b01);
        check("s6_level", bus.key_level, 2'b10);
        bus.key_n = 2'b11;
        run(20);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                bus.key_n[$urandom_range(0, NK - 1)] ^= 1'b1;
            end
            Reset = ($urandom_range(0, 399) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
